// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control FSM.
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_EXEC_R,
        S_ALU_WB,
        S_BEQ
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ALU_OP_ADD,
        ALU_OP_SUB,
        ALU_OP_FUNC
    } alu_op_t;

    localparam logic [2:0] ALU_ADD     = 3'b000;
    localparam logic [2:0] ALU_SUB     = 3'b001;
    localparam logic [2:0] ALU_AND     = 3'b010;
    localparam logic [2:0] ALU_OR      = 3'b011;
    localparam logic [2:0] ALU_INVALID = 3'b111;

    localparam logic       ADR_PC      = 1'b0;
    localparam logic       ADR_ALU_OUT = 1'b1;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
    localparam logic [1:0] SRC_A_RS1    = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RES_ALU_OUT = 2'b00;
    localparam logic [1:0] RES_MEM     = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

    // States that issue a memory request and may have to wait for mem_ready.
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Maps the FSM's ALU request plus R-type func fields onto the ALU control code.
module multicycle_controller_alu_decoder
    import multicycle_controller_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    output logic [2:0] alu_control
);

    // Decode add/sub directly; R-type falls back to func3/func7.
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALU_OP_ADD: alu_control = ALU_ADD;
            ALU_OP_SUB: alu_control = ALU_SUB;
            ALU_OP_FUNC: begin
                case (func3)
                    3'b000:  alu_control = (func7 == 7'b0100000) ? ALU_SUB : ALU_ADD;
                    3'b111:  alu_control = ALU_AND;
                    3'b110:  alu_control = ALU_OR;
                    default: alu_control = ALU_INVALID;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for a shared-memory, shared-ALU multi-cycle RV32I datapath
// (lw, sw, add/sub/and/or, beq) with a memory-wait timeout.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_source,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_source,
    output logic [1:0] imm_source,
    output logic [2:0] alu_control,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       mem_error
);

    // Wide enough to hold MEM_TIMEOUT-1, and at least one bit when the timer is disabled.
    localparam int TW = $clog2(MEM_TIMEOUT + 2);

    state_t        r_state;
    state_t        w_next_state;
    logic [TW-1:0] r_timer;
    logic          w_mem_wait;
    logic          w_timeout;
    alu_op_t       w_alu_op;

    assign w_mem_wait = is_mem_state(r_state) && !mem_ready;
    // mem_ready in the final cycle suppresses the timeout because w_mem_wait is then 0.
    assign w_timeout  = (MEM_TIMEOUT != 0) && w_mem_wait
                        && (r_timer == TW'(MEM_TIMEOUT - 1));

    multicycle_controller_alu_decoder u_alu_decoder (
        .alu_op      (w_alu_op),
        .func3       (func3),
        .func7       (func7),
        .alu_control (alu_control)
    );

    // Next-state selection from the current state, opcode and handshake.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH: begin
                if (mem_ready)      w_next_state = S_DECODE;
                else if (w_timeout) w_next_state = S_FETCH;
            end
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: w_next_state = S_MEM_ADR;
                    OP_R:              w_next_state = S_EXEC_R;
                    OP_BRANCH:         w_next_state = S_BEQ;
                    default:           w_next_state = S_FETCH;
                endcase
            end
            S_MEM_ADR:   w_next_state = (op == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ: begin
                if (mem_ready)      w_next_state = S_MEM_WB;
                else if (w_timeout) w_next_state = S_FETCH;
            end
            S_MEM_WB:    w_next_state = S_FETCH;
            S_MEM_WRITE: begin
                if (mem_ready || w_timeout) w_next_state = S_FETCH;
            end
            S_EXEC_R:    w_next_state = S_ALU_WB;
            S_ALU_WB:    w_next_state = S_FETCH;
            S_BEQ:       w_next_state = S_FETCH;
            default:     w_next_state = S_FETCH;
        endcase
    end

    // State register and memory-wait timer; the timer restarts on any transition or timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_timer <= '0;
        end else begin
            r_state <= w_next_state;
            if ((w_next_state != r_state) || w_timeout)
                r_timer <= '0;
            else if (w_mem_wait && (MEM_TIMEOUT != 0))
                r_timer <= r_timer + 1'b1;
        end
    end

    // Moore output decode; pc_write/ir_write/instr_done/mem_error also look at this cycle's inputs.
    always_comb begin
        mem_req       = 1'b0;
        mem_write     = 1'b0;
        adr_source    = ADR_PC;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = SRC_A_PC;
        alu_src_b     = SRC_B_RS2;
        result_source = RES_ALU_OUT;
        imm_source    = IMM_I;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;
        mem_error     = 1'b0;
        w_alu_op      = ALU_OP_ADD;
        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    adr_source    = ADR_PC;
                    mem_req       = !w_timeout;
                    alu_src_a     = SRC_A_PC;
                    alu_src_b     = SRC_B_FOUR;
                    result_source = RES_ALU;
                    ir_write      = mem_ready;
                    pc_write      = mem_ready;
                    mem_error     = w_timeout;
                end
                S_DECODE: begin
                    alu_src_a  = SRC_A_OLD_PC;
                    alu_src_b  = SRC_B_IMM;
                    imm_source = IMM_B;
                    illegal_op = !((op == OP_LOAD) || (op == OP_STORE)
                                   || (op == OP_R) || (op == OP_BRANCH));
                end
                S_MEM_ADR: begin
                    alu_src_a  = SRC_A_RS1;
                    alu_src_b  = SRC_B_IMM;
                    imm_source = (op == OP_STORE) ? IMM_S : IMM_I;
                end
                S_MEM_READ: begin
                    adr_source = ADR_ALU_OUT;
                    mem_req    = !w_timeout;
                    mem_error  = w_timeout;
                end
                S_MEM_WB: begin
                    result_source = RES_MEM;
                    reg_write     = 1'b1;
                    instr_done    = 1'b1;
                end
                S_MEM_WRITE: begin
                    adr_source = ADR_ALU_OUT;
                    mem_req    = !w_timeout;
                    mem_write  = !w_timeout;
                    instr_done = mem_ready;
                    mem_error  = w_timeout;
                end
                S_EXEC_R: begin
                    alu_src_a = SRC_A_RS1;
                    alu_src_b = SRC_B_RS2;
                    w_alu_op  = ALU_OP_FUNC;
                end
                S_ALU_WB: begin
                    result_source = RES_ALU_OUT;
                    reg_write     = 1'b1;
                    instr_done    = 1'b1;
                end
                S_BEQ: begin
                    alu_src_a     = SRC_A_RS1;
                    alu_src_b     = SRC_B_RS2;
                    w_alu_op      = ALU_OP_SUB;
                    result_source = RES_ALU_OUT;
                    instr_done    = 1'b1;
                    pc_write      = alu_zero && (func3 == 3'b000);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller: per-cycle expected outputs are queued with the stimulus
// and compared against the DUT at the falling edge.
module tb_multicycle_controller;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] BAD = 7'b1111111;

    typedef struct {
        logic       rst;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       zero;
        logic       rdy;
    } stim_t;

    // stb = {mem_req, mem_write, ir_write, pc_write, reg_write, instr_done, illegal_op, mem_error}
    // sel = {adr_source, alu_src_a, alu_src_b, result_source, imm_source, alu_control}
    typedef struct {
        logic [7:0]  stb;
        logic [11:0] sel;
        logic [11:0] selm;
    } exp_t;

    logic clk = 1'b0;
    logic rst, alu_zero, mem_ready;
    logic [6:0] op, func7;
    logic [2:0] func3;
    logic use4;

    logic a_req, a_wr, a_adr, a_ir, a_pc, a_rw, a_done, a_ill, a_err;
    logic [1:0] a_sa, a_sb, a_res, a_imm;
    logic [2:0] a_alu;
    logic b_req, b_wr, b_adr, b_ir, b_pc, b_rw, b_done, b_ill, b_err;
    logic [1:0] b_sa, b_sb, b_res, b_imm;
    logic [2:0] b_alu;

    int errors = 0;
    int checks = 0;
    stim_t sq[$];
    exp_t  sb[$];

    always #5 clk = ~clk;

    multicycle_controller #(.MEM_TIMEOUT(16)) dut16 (
        .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7),
        .alu_zero(alu_zero), .mem_ready(mem_ready),
        .mem_req(a_req), .mem_write(a_wr), .adr_source(a_adr), .ir_write(a_ir),
        .pc_write(a_pc), .reg_write(a_rw), .alu_src_a(a_sa), .alu_src_b(a_sb),
        .result_source(a_res), .imm_source(a_imm), .alu_control(a_alu),
        .instr_done(a_done), .illegal_op(a_ill), .mem_error(a_err)
    );

    multicycle_controller #(.MEM_TIMEOUT(4)) dut4 (
        .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7),
        .alu_zero(alu_zero), .mem_ready(mem_ready),
        .mem_req(b_req), .mem_write(b_wr), .adr_source(b_adr), .ir_write(b_ir),
        .pc_write(b_pc), .reg_write(b_rw), .alu_src_a(b_sa), .alu_src_b(b_sb),
        .result_source(b_res), .imm_source(b_imm), .alu_control(b_alu),
        .instr_done(b_done), .illegal_op(b_ill), .mem_error(b_err)
    );

    wire [7:0]  w_stb_a = {a_req, a_wr, a_ir, a_pc, a_rw, a_done, a_ill, a_err};
    wire [11:0] w_sel_a = {a_adr, a_sa, a_sb, a_res, a_imm, a_alu};
    wire [7:0]  w_stb_b = {b_req, b_wr, b_ir, b_pc, b_rw, b_done, b_ill, b_err};
    wire [11:0] w_sel_b = {b_adr, b_sa, b_sb, b_res, b_imm, b_alu};
    wire [7:0]  obs_stb = use4 ? w_stb_b : w_stb_a;
    wire [11:0] obs_sel = use4 ? w_sel_b : w_sel_a;

    // ---------------- expectation builders ----------------
    function automatic exp_t mk(logic [7:0] s, logic [11:0] v, logic [11:0] m);
        exp_t e;
        e.stb = s; e.sel = v; e.selm = m;
        return e;
    endfunction
    function automatic exp_t x_rst();
        return mk(8'b0, 12'b0, 12'hFFF);
    endfunction
    function automatic exp_t x_fetch(logic r);
        return mk({1'b1, 1'b0, r, r, 4'b0000}, {1'b0, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000},
                  12'b1_11_11_11_00_111);
    endfunction
    function automatic exp_t x_fetch_to();
        return mk(8'b0000_0001, {1'b0, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000},
                  12'b1_11_11_11_00_111);
    endfunction
    function automatic exp_t x_decode(logic ill);
        return mk({6'b0, ill, 1'b0}, {1'b0, 2'b01, 2'b01, 2'b00, 2'b10, 3'b000},
                  12'b0_11_11_00_11_111);
    endfunction
    function automatic exp_t x_madr(logic is_sw);
        return mk(8'b0, {1'b0, 2'b10, 2'b01, 2'b00, (is_sw ? 2'b01 : 2'b00), 3'b000},
                  12'b0_11_11_00_11_111);
    endfunction
    function automatic exp_t x_mread();
        return mk(8'b1000_0000, 12'b1_00_00_00_00_000, 12'b1_00_00_00_00_000);
    endfunction
    function automatic exp_t x_mwb();
        return mk(8'b0000_1100, 12'b0_00_00_01_00_000, 12'b0_00_00_11_00_000);
    endfunction
    function automatic exp_t x_mwrite(logic r);
        return mk({2'b11, 3'b000, r, 2'b00}, 12'b1_00_00_00_00_000, 12'b1_00_00_00_00_000);
    endfunction
    function automatic exp_t x_exec(logic [2:0] alu);
        return mk(8'b0, {1'b0, 2'b10, 2'b00, 2'b00, 2'b00, alu}, 12'b0_11_11_00_00_111);
    endfunction
    function automatic exp_t x_alwb();
        return mk(8'b0000_1100, 12'b0_00_00_00_00_000, 12'b0_00_00_11_00_000);
    endfunction
    function automatic exp_t x_beq(logic pc);
        return mk({3'b000, pc, 1'b0, 1'b1, 2'b00}, {1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 3'b001},
                  12'b0_11_11_11_00_111);
    endfunction

    function automatic stim_t st(logic r, logic [6:0] o, logic [2:0] f3, logic [6:0] f7,
                                 logic z, logic rdy);
        stim_t s;
        s.rst = r; s.op = o; s.f3 = f3; s.f7 = f7; s.zero = z; s.rdy = rdy;
        return s;
    endfunction

    task automatic add(input stim_t s, input exp_t e);
        sq.push_back(s);
        sb.push_back(e);
    endtask

    task automatic drive(input stim_t s);
        rst = s.rst; op = s.op; func3 = s.f3; func7 = s.f7;
        alu_zero = s.zero; mem_ready = s.rdy;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        stim_t s; exp_t e; int i;
        use4 = 1'b0;
        add(st(1, LW, 3'b0, 7'b0, 1, 1), x_rst());
        add(st(1, LW, 3'b0, 7'b0, 1, 1), x_rst());
        add(st(0, LW, 3'b0, 7'b0, 0, 0), x_fetch(0));
        add(st(0, LW, 3'b0, 7'b0, 0, 1), x_fetch(1));
        i = 0;
        while (sq.size() > 0) begin
            s = sq.pop_front(); drive(s);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs_stb !== e.stb) begin
                errors++; $display("FAIL reset[%0d] strobes: got %b want %b", i, obs_stb, e.stb);
            end
            checks++;
            if ((obs_sel & e.selm) !== (e.sel & e.selm)) begin
                errors++; $display("FAIL reset[%0d] selects: got %b want %b", i, obs_sel & e.selm, e.sel & e.selm);
            end
            @(posedge clk); #1; i++;
        end
    endtask

    task automatic test_lw();
        stim_t s; exp_t e; int i;
        use4 = 1'b0;
        add(st(1, LW, 3'b010, 7'b0, 0, 1), x_rst());
        add(st(0, LW, 3'b010, 7'b0, 0, 1), x_fetch(1));
        add(st(0, LW, 3'b010, 7'b0, 0, 1), x_decode(0));
        add(st(0, LW, 3'b010, 7'b0, 0, 1), x_madr(0));
        add(st(0, LW, 3'b010, 7'b0, 0, 1), x_mread());
        add(st(0, LW, 3'b010, 7'b0, 0, 1), x_mwb());
        add(st(0, LW, 3'b010, 7'b0, 0, 0), x_fetch(0));
        i = 0;
        while (sq.size() > 0) begin
            s = sq.pop_front(); drive(s);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs_stb !== e.stb) begin
                errors++; $display("FAIL lw[%0d] strobes: got %b want %b", i, obs_stb, e.stb);
            end
            checks++;
            if ((obs_sel & e.selm) !== (e.sel & e.selm)) begin
                errors++; $display("FAIL lw[%0d] selects: got %b want %b", i, obs_sel & e.selm, e.sel & e.selm);
            end
            @(posedge clk); #1; i++;
        end
    endtask

    task automatic test_beq();
        stim_t s; exp_t e; int i;
        use4 = 1'b0;
        add(st(1, BR, 3'b000, 7'b0, 1, 1), x_rst());
        add(st(0, BR, 3'b000, 7'b0, 1, 1), x_fetch(1));
        add(st(0, BR, 3'b000, 7'b0, 1, 1), x_decode(0));
        add(st(0, BR, 3'b000, 7'b0, 1, 1), x_beq(1));
        add(st(0, BR, 3'b000, 7'b0, 0, 1), x_fetch(1));
        add(st(0, BR, 3'b000, 7'b0, 0, 1), x_decode(0));
        add(st(0, BR, 3'b000, 7'b0, 0, 1), x_beq(0));
        add(st(0, BR, 3'b001, 7'b0, 1, 1), x_fetch(1));
        add(st(0, BR, 3'b001, 7'b0, 1, 1), x_decode(0));
        add(st(0, BR, 3'b001, 7'b0, 1, 1), x_beq(0));
        add(st(0, BR, 3'b000, 7'b0, 0, 0), x_fetch(0));
        i = 0;
        while (sq.size() > 0) begin
            s = sq.pop_front(); drive(s);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs_stb !== e.stb) begin
                errors++; $display("FAIL beq[%0d] strobes: got %b want %b", i, obs_stb, e.stb);
            end
            checks++;
            if ((obs_sel & e.selm) !== (e.sel & e.selm)) begin
                errors++; $display("FAIL beq[%0d] selects: got %b want %b", i, obs_sel & e.selm, e.sel & e.selm);
            end
            @(posedge clk); #1; i++;
        end
    endtask

    task automatic test_sw_wait();
        stim_t s; exp_t e; int i;
        use4 = 1'b0;
        add(st(1, SW, 3'b010, 7'b0, 0, 1), x_rst());
        add(st(0, SW, 3'b010, 7'b0, 0, 1), x_fetch(1));
        add(st(0, SW, 3'b010, 7'b0, 0, 1), x_decode(0));
        add(st(0, SW, 3'b010, 7'b0, 0, 1), x_madr(1));
        for (int k = 0; k < 5; k++)
            add(st(0, SW, 3'b010, 7'b0, 0, 0), x_mwrite(0));
        add(st(0, SW, 3'b010, 7'b0, 0, 1), x_mwrite(1));
        add(st(0, SW, 3'b010, 7'b0, 0, 0), x_fetch(0));
        i = 0;
        while (sq.size() > 0) begin
            s = sq.pop_front(); drive(s);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs_stb !== e.stb) begin
                errors++; $display("FAIL sw_wait[%0d] strobes: got %b want %b", i, obs_stb, e.stb);
            end
            checks++;
            if ((obs_sel & e.selm) !== (e.sel & e.selm)) begin
                errors++; $display("FAIL sw_wait[%0d] selects: got %b want %b", i, obs_sel & e.selm, e.sel & e.selm);
            end
            @(posedge clk); #1; i++;
        end
    endtask

    task automatic test_decode_alu();
        stim_t s; exp_t e; int i;
        logic [2:0] f3s [4];
        logic [6:0] f7s [4];
        logic [2:0] alus[4];
        f3s[0] = 3'b000; f7s[0] = 7'b0100000; alus[0] = 3'b001;
        f3s[1] = 3'b000; f7s[1] = 7'b0000000; alus[1] = 3'b000;
        f3s[2] = 3'b111; f7s[2] = 7'b0000000; alus[2] = 3'b010;
        f3s[3] = 3'b110; f7s[3] = 7'b0000000; alus[3] = 3'b011;
        use4 = 1'b0;
        add(st(1, BAD, 3'b0, 7'b0, 0, 1), x_rst());
        add(st(0, BAD, 3'b0, 7'b0, 0, 1), x_fetch(1));
        add(st(0, BAD, 3'b0, 7'b0, 0, 1), x_decode(1));
        add(st(0, BAD, 3'b0, 7'b0, 0, 0), x_fetch(0));
        add(st(0, RT, 3'b010, 7'b0, 0, 1), x_fetch(1));
        add(st(0, RT, 3'b010, 7'b0, 0, 1), x_decode(0));
        add(st(0, RT, 3'b010, 7'b0, 0, 1), x_exec(3'b111));
        add(st(0, RT, 3'b010, 7'b0, 0, 1), x_alwb());
        for (int k = 0; k < 4; k++) begin
            add(st(0, RT, f3s[k], f7s[k], 0, 1), x_fetch(1));
            add(st(0, RT, f3s[k], f7s[k], 0, 1), x_decode(0));
            add(st(0, RT, f3s[k], f7s[k], 0, 1), x_exec(alus[k]));
            add(st(0, RT, f3s[k], f7s[k], 0, 1), x_alwb());
        end
        i = 0;
        while (sq.size() > 0) begin
            s = sq.pop_front(); drive(s);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs_stb !== e.stb) begin
                errors++; $display("FAIL decode_alu[%0d] strobes: got %b want %b", i, obs_stb, e.stb);
            end
            checks++;
            if ((obs_sel & e.selm) !== (e.sel & e.selm)) begin
                errors++; $display("FAIL decode_alu[%0d] selects: got %b want %b", i, obs_sel & e.selm, e.sel & e.selm);
            end
            @(posedge clk); #1; i++;
        end
    endtask

    task automatic test_timeout();
        stim_t s; exp_t e; int i;
        use4 = 1'b1;
        add(st(1, LW, 3'b010, 7'b0, 0, 0), x_rst());
        for (int k = 0; k < 3; k++) add(st(0, LW, 3'b010, 7'b0, 0, 0), x_fetch(0));
        add(st(0, LW, 3'b010, 7'b0, 0, 0), x_fetch_to());
        for (int k = 0; k < 3; k++) add(st(0, LW, 3'b010, 7'b0, 0, 0), x_fetch(0));
        add(st(0, LW, 3'b010, 7'b0, 0, 1), x_fetch(1));
        add(st(0, LW, 3'b010, 7'b0, 0, 1), x_decode(0));
        add(st(0, LW, 3'b010, 7'b0, 0, 1), x_madr(0));
        add(st(0, LW, 3'b010, 7'b0, 0, 0), x_mread());
        add(st(0, LW, 3'b010, 7'b0, 0, 0), x_mread());
        add(st(1, LW, 3'b010, 7'b0, 1, 1), x_rst());
        add(st(0, LW, 3'b010, 7'b0, 0, 0), x_fetch(0));
        i = 0;
        while (sq.size() > 0) begin
            s = sq.pop_front(); drive(s);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs_stb !== e.stb) begin
                errors++; $display("FAIL timeout[%0d] strobes: got %b want %b", i, obs_stb, e.stb);
            end
            checks++;
            if ((obs_sel & e.selm) !== (e.sel & e.selm)) begin
                errors++; $display("FAIL timeout[%0d] selects: got %b want %b", i, obs_sel & e.selm, e.sel & e.selm);
            end
            @(posedge clk); #1; i++;
        end
    endtask

    task automatic test_timeout_race();
        stim_t s; exp_t e; int i;
        use4 = 1'b1;
        add(st(1, BAD, 3'b0, 7'b0, 0, 0), x_rst());
        for (int k = 0; k < 3; k++) add(st(0, BAD, 3'b0, 7'b0, 0, 0), x_fetch(0));
        add(st(0, BAD, 3'b0, 7'b0, 0, 1), x_fetch(1));
        add(st(0, BAD, 3'b0, 7'b0, 0, 0), x_decode(1));
        add(st(0, BAD, 3'b0, 7'b0, 0, 0), x_fetch(0));
        i = 0;
        while (sq.size() > 0) begin
            s = sq.pop_front(); drive(s);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs_stb !== e.stb) begin
                errors++; $display("FAIL race[%0d] strobes: got %b want %b", i, obs_stb, e.stb);
            end
            checks++;
            if ((obs_sel & e.selm) !== (e.sel & e.selm)) begin
                errors++; $display("FAIL race[%0d] selects: got %b want %b", i, obs_sel & e.selm, e.sel & e.selm);
            end
            @(posedge clk); #1; i++;
        end
    endtask

    initial begin
        rst = 1'b1; op = 7'b0; func3 = 3'b0; func7 = 7'b0;
        alu_zero = 1'b0; mem_ready = 1'b0; use4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_lw();
        test_beq();
        test_sw_wait();
        test_decode_alu();
        test_timeout();
        test_timeout_race();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
